// File: rtl/jtbubl_sdram_sched.sv
// Four-slot read scheduler for the Bubble Bobble SDRAM: one 32-bit cache line per slot,
// round-robin arbitration and a single outstanding SDRAM read at a time.
module jtbubl_sdram_sched #(
  parameter logic [21:0] OFF0 = 22'h0,
  parameter logic [21:0] OFF1 = 22'h0,
  parameter logic [21:0] OFF2 = 22'h0,
  parameter logic [21:0] OFF3 = 22'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        slot0_cs,
  input  logic [17:0] slot0_addr,
  output logic [7:0]  slot0_dout,
  output logic        slot0_ok,
  input  logic        slot1_cs,
  input  logic [17:0] slot1_addr,
  output logic [7:0]  slot1_dout,
  output logic        slot1_ok,
  input  logic        slot2_cs,
  input  logic [17:0] slot2_addr,
  output logic [7:0]  slot2_dout,
  output logic        slot2_ok,
  input  logic        slot3_cs,
  input  logic [17:0] slot3_addr,
  output logic [7:0]  slot3_dout,
  output logic        slot3_ok,
  input  logic        downloading,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic        refresh_en
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [3:0]  w_cs;
  logic [17:0] w_addr [4];
  logic [21:0] w_off  [4];
  logic [3:0]  w_ok;
  logic [3:0]  w_pend;
  logic [7:0]  w_dout [4];

  logic [3:0]  r_valid;
  logic [15:0] r_tag  [4];
  logic [31:0] r_data [4];

  logic [1:0]  r_ptr;
  logic [1:0]  r_win;
  logic [15:0] r_ltag;
  logic        r_sdram_req;
  logic [21:0] r_sdram_addr;

  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_found;
  logic        w_launch;
  logic        w_fill;
  logic        w_ack_req;

  assign w_cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign w_addr[0] = slot0_addr;
  assign w_addr[1] = slot1_addr;
  assign w_addr[2] = slot2_addr;
  assign w_addr[3] = slot3_addr;
  assign w_off[0]  = OFF0;
  assign w_off[1]  = OFF1;
  assign w_off[2]  = OFF2;
  assign w_off[3]  = OFF3;

  assign slot0_ok   = w_ok[0];
  assign slot1_ok   = w_ok[1];
  assign slot2_ok   = w_ok[2];
  assign slot3_ok   = w_ok[3];
  assign slot0_dout = w_dout[0];
  assign slot1_dout = w_dout[1];
  assign slot2_dout = w_dout[2];
  assign slot3_dout = w_dout[3];

  assign sdram_req  = r_sdram_req;
  assign sdram_addr = r_sdram_addr;

  // Hit detection and byte lane selection per slot
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_ok[n]   = w_cs[n] & r_valid[n] & (r_tag[n] == w_addr[n][17:2]);
      w_pend[n] = w_cs[n] & ~w_ok[n];
      case (w_addr[n][1:0])
        2'd0:    w_dout[n] = r_data[n][7:0];
        2'd1:    w_dout[n] = r_data[n][15:8];
        2'd2:    w_dout[n] = r_data[n][23:16];
        default: w_dout[n] = r_data[n][31:24];
      endcase
    end
  end

  // Round-robin pick: first pending slot at or after the pointer
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_pend[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; a ROM download always forces the scheduler back to idle
  always_comb begin
    w_state_nx = r_state;
    if (downloading) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) w_state_nx = ST_REQ;
          else         w_state_nx = ST_IDLE;
        end
        ST_REQ: begin
          if (sdram_ack && data_rdy) w_state_nx = ST_IDLE;
          else if (sdram_ack)        w_state_nx = ST_WAIT;
          else                       w_state_nx = ST_REQ;
        end
        ST_WAIT: begin
          if (data_rdy) w_state_nx = ST_IDLE;
          else          w_state_nx = ST_WAIT;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Output/control decode from the current state
  always_comb begin
    w_launch   = 1'b0;
    w_fill     = 1'b0;
    w_ack_req  = 1'b0;
    refresh_en = 1'b0;
    if (!rstn || downloading) begin
      refresh_en = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_launch   = w_found;
          refresh_en = ~|w_pend;
        end
        ST_REQ: begin
          w_ack_req = sdram_ack;
          w_fill    = sdram_ack & data_rdy;
        end
        ST_WAIT: begin
          w_fill = data_rdy;
        end
        default: begin
          w_launch = 1'b0;
        end
      endcase
    end
  end

  // Request handshake and latched transaction context
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sdram_req  <= 1'b0;
      r_sdram_addr <= 22'd0;
      r_win        <= 2'd0;
      r_ltag       <= 16'd0;
    end else if (downloading) begin
      r_sdram_req  <= 1'b0;
    end else if (w_launch) begin
      r_sdram_req  <= 1'b1;
      r_sdram_addr <= w_off[w_win] + {5'd0, w_addr[w_win][17:2], 1'b0};
      r_win        <= w_win;
      r_ltag       <= w_addr[w_win][17:2];
    end else if (w_ack_req) begin
      r_sdram_req  <= 1'b0;
    end else begin
      r_sdram_req  <= r_sdram_req;
    end
  end

  // Cache lines; the fill uses the tag latched at launch, not the live address
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 4'd0;
      r_ptr   <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        r_tag[n]  <= 16'd0;
        r_data[n] <= 32'd0;
      end
    end else if (downloading) begin
      r_valid <= 4'd0;
    end else if (w_fill) begin
      r_valid[r_win] <= 1'b1;
      r_tag[r_win]   <= r_ltag;
      r_data[r_win]  <= data_read;
      r_ptr          <= r_win + 2'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: tb/tb_jtbubl_sdram_sched.sv
// Self-checking bench for jtbubl_sdram_sched: directed scenarios plus a randomized run
// against a transaction-level cache/arbiter model, with the bench acting as SDRAM controller.
module tb_jtbubl_sdram_sched;
  localparam logic [21:0] P_OFF0 = 22'h000100;
  localparam logic [21:0] P_OFF1 = 22'h014000;
  localparam logic [21:0] P_OFF2 = 22'h200000;
  localparam logic [21:0] P_OFF3 = 22'h3FFFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  cs = 4'd0;
  logic [17:0] addr [4];
  wire  [7:0]  dout [4];
  wire  [3:0]  ok;
  logic        downloading = 1'b0;
  wire         sdram_req;
  wire  [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = 32'd0;
  wire         refresh_en;

  int checks = 0;
  int failures = 0;

  bit          m_valid [4];
  logic [15:0] m_tag   [4];
  logic [31:0] m_data  [4];
  int          m_ptr;

  jtbubl_sdram_sched #(.OFF0(P_OFF0), .OFF1(P_OFF1), .OFF2(P_OFF2), .OFF3(P_OFF3)) dut (
    .clk(clk), .rstn(rstn),
    .slot0_cs(cs[0]), .slot0_addr(addr[0]), .slot0_dout(dout[0]), .slot0_ok(ok[0]),
    .slot1_cs(cs[1]), .slot1_addr(addr[1]), .slot1_dout(dout[1]), .slot1_ok(ok[1]),
    .slot2_cs(cs[2]), .slot2_addr(addr[2]), .slot2_dout(dout[2]), .slot2_ok(ok[2]),
    .slot3_cs(cs[3]), .slot3_addr(addr[3]), .slot3_dout(dout[3]), .slot3_ok(ok[3]),
    .downloading(downloading), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] m_off(int n);
    case (n)
      0:       return P_OFF0;
      1:       return P_OFF1;
      2:       return P_OFF2;
      default: return P_OFF3;
    endcase
  endfunction

  function automatic logic m_ok(int n);
    return cs[n] && m_valid[n] && (m_tag[n] == addr[n][17:2]);
  endfunction

  function automatic logic [7:0] m_dout(int n);
    logic [31:0] sh;
    sh = m_data[n] >> (8 * addr[n][1:0]);
    return sh[7:0];
  endfunction

  function automatic logic [21:0] m_addr(int n);
    logic [21:0] word;
    word = 22'(addr[n][17:2]) * 22'd2;
    return m_off(n) + word;
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < 4; k++) begin
      if (cs[(m_ptr + k) % 4] && !m_ok((m_ptr + k) % 4)) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic void m_fill(int n, logic [15:0] tag, logic [31:0] d);
    m_valid[n] = 1'b1;
    m_tag[n]   = tag;
    m_data[n]  = d;
    m_ptr      = (n + 1) % 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; cs = 4'd0; sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
    for (int n = 0; n < 4; n++) addr[n] = 18'd0;
    step(); step();
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      m_valid[n] = 1'b0; m_tag[n] = 16'd0; m_data[n] = 32'd0;
    end
    m_ptr = 0;
    #1;
  endtask

  // Controller side only: ack after ad cycles, data ad+rd+1 cycles later (or together)
  task automatic handshake(int ad, int rd, bit same, logic [31:0] d);
    repeat (ad) step();
    sdram_ack = 1'b1;
    if (same) begin data_rdy = 1'b1; data_read = d; end
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    if (!same) begin
      repeat (rd) step();
      data_rdy = 1'b1; data_read = d;
      step();
      data_rdy = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cs = 4'hF;
    for (int n = 0; n < 4; n++) addr[n] = 18'd0;
    step(); step();
    checks++;
    if (sdram_req !== 1'b0 || sdram_addr !== 22'd0 || refresh_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_out req=%b addr=%h ref=%b expected 0/000000/1", sdram_req, sdram_addr, refresh_en);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ok[n] !== 1'b0 || dout[n] !== 8'h00) begin
        failures++;
        $display("FAIL reset_slot%0d ok=%b dout=%h expected 0/00", n, ok[n], dout[n]);
      end
    end
    do_reset();
  endtask

  task automatic test_example();
    do_reset();
    cs[1] = 1'b1; addr[1] = 18'h00005; #1;
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h14002) begin
      failures++;
      $display("FAIL example_launch req=%b addr=%h expected 1/014002", sdram_req, sdram_addr);
    end
    handshake(2, 2, 1'b0, 32'hDDCCBBAA);
    m_fill(1, 16'h0001, 32'hDDCCBBAA);
    checks++;
    if (ok[1] !== 1'b1 || dout[1] !== 8'hBB || sdram_req !== 1'b0) begin
      failures++;
      $display("FAIL example_fill ok=%b dout=%h req=%b expected 1/bb/0", ok[1], dout[1], sdram_req);
    end
  endtask

  task automatic test_order();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] d;
    do_reset();
    cs = 4'hF;
    for (int n = 0; n < 4; n++) addr[n] = 18'(32'h10 * (n + 1));
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== m_addr(order[i])) begin
        failures++;
        $display("FAIL order_%0d req=%b addr=%h expected 1/%h", i, sdram_req, sdram_addr, m_addr(order[i]));
      end
      d = $urandom;
      handshake(0, 0, 1'b0, d);
      m_fill(order[i], addr[order[i]][17:2], d);
      checks++;
      if (ok[order[i]] !== 1'b1 || dout[order[i]] !== m_dout(order[i])) begin
        failures++;
        $display("FAIL order_fill%0d ok=%b dout=%h expected 1/%h", i, ok[order[i]], dout[order[i]], m_dout(order[i]));
      end
      if (i == 0) begin addr[0] = 18'h00200; #1; end
    end
  endtask

  task automatic test_hit();
    do_reset();
    cs[0] = 1'b1; addr[0] = 18'd4; #1;
    step();
    handshake(0, 1, 1'b0, 32'h44332211);
    m_fill(0, 16'h0001, 32'h44332211);
    addr[0] = 18'd7; #1;
    checks++;
    if (ok[0] !== 1'b1 || dout[0] !== 8'h44) begin
      failures++;
      $display("FAIL hit_byte3 ok=%b dout=%h expected 1/44", ok[0], dout[0]);
    end
    step();
    checks++;
    if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
      failures++;
      $display("FAIL hit_noreq req=%b ref=%b expected 0/1", sdram_req, refresh_en);
    end
    addr[0] = 18'd8; #1;
    checks++;
    if (ok[0] !== 1'b0 || refresh_en !== 1'b0) begin
      failures++;
      $display("FAIL miss_ok ok=%b ref=%b expected 0/0", ok[0], refresh_en);
    end
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== m_addr(0)) begin
      failures++;
      $display("FAIL miss_req req=%b addr=%h expected 1/%h", sdram_req, sdram_addr, m_addr(0));
    end
    handshake(1, 0, 1'b1, 32'h88776655);
    m_fill(0, 16'h0002, 32'h88776655);
  endtask

  task automatic test_download();
    do_reset();
    cs[2] = 1'b1; addr[2] = 18'h40; #1;
    step();
    handshake(0, 0, 1'b0, 32'hCAFEF00D);
    m_fill(2, 16'h0010, 32'hCAFEF00D);
    addr[2] = 18'h80; #1;
    step();
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    downloading = 1'b1; #1;
    step();
    for (int n = 0; n < 4; n++) m_valid[n] = 1'b0;
    checks++;
    if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
      failures++;
      $display("FAIL dl_hold req=%b ref=%b expected 0/1", sdram_req, refresh_en);
    end
    cs = 4'd0; step();
    downloading = 1'b0; #1;
    checks++;
    if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
      failures++;
      $display("FAIL dl_idle req=%b ref=%b expected 0/1", sdram_req, refresh_en);
    end
    data_rdy = 1'b1; data_read = 32'h12345678; step(); data_rdy = 1'b0;
    cs[2] = 1'b1; #1;
    checks++;
    if (ok[2] !== 1'b0) begin
      failures++;
      $display("FAIL dl_late_rdy ok=%b expected 0", ok[2]);
    end
    addr[2] = 18'h40; #1;
    checks++;
    if (ok[2] !== 1'b0) begin
      failures++;
      $display("FAIL dl_cleared ok=%b expected 0", ok[2]);
    end
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== m_addr(2)) begin
      failures++;
      $display("FAIL dl_refetch req=%b addr=%h expected 1/%h", sdram_req, sdram_addr, m_addr(2));
    end
    handshake(0, 0, 1'b0, 32'h0BADBEEF);
    m_fill(2, 16'h0010, 32'h0BADBEEF);
    checks++;
    if (ok[2] !== 1'b1 || dout[2] !== m_dout(2)) begin
      failures++;
      $display("FAIL dl_refill ok=%b dout=%h expected 1/%h", ok[2], dout[2], m_dout(2));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cs[3] = 1'b1; addr[3] = 18'h00100; #1;
    step();
    rstn = 1'b0; #1;
    checks++;
    if (refresh_en !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ref ref=%b expected 1", refresh_en);
    end
    step();
    rstn = 1'b1; cs = 4'd0; #1;
    checks++;
    if (sdram_req !== 1'b0 || refresh_en !== 1'b1 || sdram_addr !== 22'd0) begin
      failures++;
      $display("FAIL rstmid_out req=%b ref=%b addr=%h expected 0/1/000000", sdram_req, refresh_en, sdram_addr);
    end
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h55AA55AA;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    cs[3] = 1'b1; #1;
    checks++;
    if (ok[3] !== 1'b0 || dout[3] !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_nowrite ok=%b dout=%h expected 0/00", ok[3], dout[3]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cs[3] = 1'b1; addr[3] = 18'h00004; #1;
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000001) begin
      failures++;
      $display("FAIL wrap_addr req=%b addr=%h expected 1/000001", sdram_req, sdram_addr);
    end
    handshake(0, 0, 1'b1, 32'h01020304);
    m_fill(3, 16'h0001, 32'h01020304);
  endtask

  task automatic test_ignore();
    do_reset();
    cs[0] = 1'b1; addr[0] = 18'h0; #1;
    step();
    handshake(0, 0, 1'b0, 32'hA1B2C3D4);
    m_fill(0, 16'h0000, 32'hA1B2C3D4);
    cs = 4'd0;
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    data_rdy = 1'b1; data_read = 32'hFFFFFFFF; step(); data_rdy = 1'b0;
    cs[0] = 1'b1; #1;
    checks++;
    if (sdram_req !== 1'b0 || ok[0] !== 1'b1 || dout[0] !== 8'hD4) begin
      failures++;
      $display("FAIL ign_idle req=%b ok=%b dout=%h expected 0/1/d4", sdram_req, ok[0], dout[0]);
    end
    cs[1] = 1'b1; addr[1] = 18'h00100; #1;
    step();
    data_rdy = 1'b1; data_read = 32'hEEEEEEEE; step(); data_rdy = 1'b0; #1;
    checks++;
    if (sdram_req !== 1'b1 || ok[1] !== 1'b0) begin
      failures++;
      $display("FAIL ign_rdy_in_req req=%b ok=%b expected 1/0", sdram_req, ok[1]);
    end
    handshake(0, 2, 1'b0, 32'h99887766);
    m_fill(1, 16'h0040, 32'h99887766);
    checks++;
    if (ok[1] !== 1'b1 || dout[1] !== 8'h66) begin
      failures++;
      $display("FAIL ign_fill ok=%b dout=%h expected 1/66", ok[1], dout[1]);
    end
  endtask

  task automatic test_random();
    int w, ad, rd;
    bit same;
    logic [15:0] ltag;
    logic [21:0] laddr;
    logic [31:0] d;
    do_reset();
    for (int it = 0; it < 200; it++) begin
      for (int n = 0; n < 4; n++) begin
        cs[n] = 1'($urandom_range(0, 1));
        addr[n] = 18'($urandom_range(0, 15)) ^ (($urandom % 4 == 0) ? 18'h2A5C0 : 18'h0);
      end
      #1;
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (ok[n] !== m_ok(n) || dout[n] !== m_dout(n)) begin
          failures++;
          $display("FAIL rnd_slot%0d it=%0d ok=%b dout=%h expected %b/%h", n, it, ok[n], dout[n], m_ok(n), m_dout(n));
        end
      end
      w = m_winner();
      checks++;
      if (refresh_en !== (w < 0)) begin
        failures++;
        $display("FAIL rnd_refresh it=%0d ref=%b expected %b", it, refresh_en, (w < 0));
      end
      laddr = (w < 0) ? 22'd0 : m_addr(w);
      step();
      checks++;
      if (w < 0) begin
        if (sdram_req !== 1'b0) begin
          failures++;
          $display("FAIL rnd_idle it=%0d req=%b expected 0", it, sdram_req);
        end
      end else begin
        if (sdram_req !== 1'b1 || sdram_addr !== laddr) begin
          failures++;
          $display("FAIL rnd_launch it=%0d req=%b addr=%h expected 1/%h", it, sdram_req, sdram_addr, laddr);
        end
        ltag = addr[w][17:2];
        ad = $urandom_range(0, 3); rd = $urandom_range(0, 3);
        same = ($urandom % 4 == 0); d = $urandom;
        if ($urandom % 4 == 0) addr[w] = 18'($urandom_range(0, 15));
        for (int c = 0; c < ad; c++) begin
          step();
          checks++;
          if (sdram_req !== 1'b1 || sdram_addr !== laddr) begin
            failures++;
            $display("FAIL rnd_hold it=%0d req=%b addr=%h expected 1/%h", it, sdram_req, sdram_addr, laddr);
          end
        end
        handshake(0, rd, same, d);
        m_fill(w, ltag, d);
        checks++;
        if (sdram_req !== 1'b0 || sdram_addr !== laddr || ok[w] !== m_ok(w)) begin
          failures++;
          $display("FAIL rnd_done it=%0d req=%b addr=%h ok=%b expected 0/%h/%b", it, sdram_req, sdram_addr, ok[w], laddr, m_ok(w));
        end
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++) addr[n] = 18'd0;
    test_reset();
    test_example();
    test_order();
    test_hit();
    test_download();
    test_reset_mid();
    test_wrap();
    test_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
